// File: rtl/dp1m4_row.sv
// One row of a weight-stationary 2:4 structured-sparse systolic MAC array; psum_out is 1 cycle after psum_in, load_out is load delayed 1 cycle.
// No backpressure: every column accepts psum_in on each execute cycle. Define DP1M4_SIGNED_EN for two's-complement weights, activations and psums.
module dp1m4_row #(
  parameter int col     = 4,
  parameter int bw      = 4,
  parameter int psum_bw = 20,
  parameter int nnz     = 8,
  parameter int ncol    = 2,
  parameter int total   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [nnz*bw-1:0]      weights_flat,
  input  logic [total-1:0]       weight_mask,
  input  logic [2*bw-1:0]        activation_flat,
  input  logic [3:0]             activation_index_flat,
  input  logic                   load,
  input  logic                   execute,
  input  logic                   a_select,
  input  logic [col*psum_bw-1:0] psum_in_flat,
  output logic                   load_out,
  output logic [col*psum_bw-1:0] psum_out_flat
);

  logic [nnz*bw-1:0]      r_w;
  logic [total-1:0]       r_m;
  logic [2*bw-1:0]        r_a;
  logic [3:0]             r_i;
  logic [col*psum_bw-1:0] r_psum;
  logic                   r_load_out;
  logic [col*psum_bw-1:0] w_psum_nxt;

  // Product of one lane against one column. The compressed weight slot is the
  // rank of the hit position among the set mask bits; ranks past ncol are dropped.
  function automatic logic [psum_bw-1:0] lane_prod(
    input logic [3:0]         m,
    input logic [1:0]         p,
    input logic [ncol*bw-1:0] wv,
    input logic [bw-1:0]      a
  );
    int               cnt;
    logic             hit;
    logic [bw-1:0]    wk;
    logic [2*bw-1:0]  prod;
    cnt  = 0;
    hit  = 1'b0;
    wk   = '0;
    for (int q = 0; q < 4; q++) begin
      if (q < int'(p) && m[q]) cnt++;
    end
    for (int kk = 0; kk < ncol; kk++) begin
      if (kk == cnt) begin
        wk  = wv[kk*bw +: bw];
        hit = m[p];
      end
    end
`ifdef DP1M4_SIGNED_EN
    prod = $signed(wk) * $signed(a);
    lane_prod = hit ? {{(psum_bw-2*bw){prod[2*bw-1]}}, prod} : '0;
`else
    prod = wk * a;
    lane_prod = hit ? {{(psum_bw-2*bw){1'b0}}, prod} : '0;
`endif
  endfunction

  for (genvar c = 0; c < col; c++) begin : g_col
    logic [psum_bw-1:0] w_prod0;
    logic [psum_bw-1:0] w_prod1;
    assign w_prod0 = lane_prod(r_m[c*4 +: 4], r_i[1:0], r_w[c*ncol*bw +: ncol*bw], r_a[bw-1:0]);
    assign w_prod1 = lane_prod(r_m[c*4 +: 4], r_i[3:2], r_w[c*ncol*bw +: ncol*bw], r_a[2*bw-1:bw]);
    // Same addition for signed and unsigned: two's-complement wrap is identical.
    assign w_psum_nxt[c*psum_bw +: psum_bw] = psum_in_flat[c*psum_bw +: psum_bw] + w_prod0 + w_prod1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w        <= '0;
      r_m        <= '0;
      r_a        <= '0;
      r_i        <= '0;
      r_psum     <= '0;
      r_load_out <= 1'b0;
    end else begin
      r_load_out <= load;
      if (load) begin
        r_w <= weights_flat;
        r_m <= weight_mask;
      end else if (!a_select) begin
        r_a <= activation_flat;
        r_i <= activation_index_flat;
      end
      // Uses the activations registered before this edge, giving the 1-cycle lag.
      if (execute && !load) begin
        r_psum <= w_psum_nxt;
      end
    end
  end

  assign load_out      = r_load_out;
  assign psum_out_flat = r_psum;

endmodule

// File: tb/tb_dp1m4_row.sv
// Randomized scoreboard bench for dp1m4_row (default unsigned build) against a behavioural model.
module tb_dp1m4_row;
  localparam int COL = 4, BW = 4, PBW = 20, NCOL = 2, NNZ = 8, TOT = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NNZ*BW-1:0]    weights_flat;
  logic [TOT-1:0]       weight_mask;
  logic [2*BW-1:0]      activation_flat;
  logic [3:0]           activation_index_flat;
  logic                 load, execute, a_select;
  logic [COL*PBW-1:0]   psum_in_flat;
  logic                 load_out;
  logic [COL*PBW-1:0]   psum_out_flat;

  dp1m4_row #(.col(COL), .bw(BW), .psum_bw(PBW), .nnz(NNZ), .ncol(NCOL), .total(TOT)) dut (
    .clk(clk), .reset(reset), .weights_flat(weights_flat), .weight_mask(weight_mask),
    .activation_flat(activation_flat), .activation_index_flat(activation_index_flat),
    .load(load), .execute(execute), .a_select(a_select), .psum_in_flat(psum_in_flat),
    .load_out(load_out), .psum_out_flat(psum_out_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COL*PBW-1:0] ps;
    logic               lo;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the spec says the row remembers.
  int unsigned mW[COL][NCOL];
  logic [3:0]  mM[COL];
  int unsigned mA[2];
  int unsigned mI[2];
  int unsigned mP[COL];
  logic        mLo;

  function automatic int unsigned ref_prod(int c, int j);
    int unsigned p, k;
    p = mI[j];
    if (!mM[c][p]) return 0;
    k = $countones(int'(mM[c]) & ((1 << p) - 1));
    if (k >= NCOL) return 0;
    return mW[c][k] * mA[j];
  endfunction

  task automatic model_step();
    exp_t e;
    if (!reset) begin
      for (int c = 0; c < COL; c++) begin
        mP[c] = 0; mM[c] = 4'd0;
        for (int k = 0; k < NCOL; k++) mW[c][k] = 0;
      end
      mA[0] = 0; mA[1] = 0; mI[0] = 0; mI[1] = 0; mLo = 1'b0;
    end else begin
      if (execute && !load)
        for (int c = 0; c < COL; c++)
          mP[c] = (int'(psum_in_flat[c*PBW +: PBW]) + ref_prod(c, 0) + ref_prod(c, 1)) % (1 << PBW);
      if (load) begin
        for (int c = 0; c < COL; c++) begin
          mM[c] = weight_mask[c*4 +: 4];
          for (int k = 0; k < NCOL; k++) mW[c][k] = weights_flat[(c*NCOL+k)*BW +: BW];
        end
      end else if (!a_select) begin
        for (int j = 0; j < 2; j++) begin
          mA[j] = activation_flat[j*BW +: BW];
          mI[j] = activation_index_flat[j*2 +: 2];
        end
      end
      mLo = load;
    end
    for (int c = 0; c < COL; c++) e.ps[c*PBW +: PBW] = mP[c][PBW-1:0];
    e.lo = mLo;
    q.push_back(e);
  endtask

  // One clock: model predicts, DUT sees the edge, monitor checks at the next negedge.
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_psum_all(input logic [PBW-1:0] v);
    for (int c = 0; c < COL; c++) psum_in_flat[c*PBW +: PBW] = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int c = 0; c < COL; c++) begin
        n_checks++;
        if (psum_out_flat[c*PBW +: PBW] !== e.ps[c*PBW +: PBW]) begin
          n_fail++;
          $display("FAIL psum_col%0d at %0t: got %0d expected %0d", c, $time,
                   psum_out_flat[c*PBW +: PBW], e.ps[c*PBW +: PBW]);
        end
      end
      n_checks++;
      if (load_out !== e.lo) begin
        n_fail++;
        $display("FAIL load_out at %0t: got %b expected %b", $time, load_out, e.lo);
      end
    end
  end

  initial begin
    reset = 1'b0; load = 1'b0; execute = 1'b1; a_select = 1'b0;
    activation_flat = '0; activation_index_flat = '0;
    for (int k = 0; k < NNZ; k++) weights_flat[k*BW +: BW] = BW'(k + 1);
    weight_mask = 16'hAAAA;
    set_psum_all(20'd10);
    @(negedge clk); #1;

    step();                                   // reset cycle
    reset = 1'b1; step();                     // psum_in=10 -> 10
    load = 1'b1; step();                      // capture weights, psum held
    load = 1'b0; activation_flat = {4'd5, 4'd3}; activation_index_flat = {2'd1, 2'd0};
    step(); step();                           // 15,25,35,45
    activation_flat = {4'd5, 4'd3}; activation_index_flat = {2'd3, 2'd0};
    step(); step();                           // 20,30,40,50
    load = 1'b1; activation_flat = '0; activation_index_flat = '0; set_psum_all(20'd77);
    step();                                   // held, activations frozen
    load = 1'b0; a_select = 1'b1; set_psum_all(20'd10);
    step(); step();                           // still 20..50 from retained activations
    a_select = 1'b0; activation_flat = {4'd7, 4'd7}; activation_index_flat = {2'd0, 2'd0};
    step(); step();                           // mask bit 0 clear -> 10
    activation_flat = {4'd5, 4'd5}; activation_index_flat = {2'd1, 2'd1};
    step(); step();                           // both lanes hit same weight
    execute = 1'b0; set_psum_all(20'd99);
    step(); step();                           // hold
    execute = 1'b1; set_psum_all(20'hFFFFF);
    activation_flat = {4'd5, 4'd3}; activation_index_flat = {2'd1, 2'd0};
    step(); step();                           // col0 wraps to 4
    reset = 1'b0; step();                     // mid-op reset -> zeros
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 7) == 0);
      execute  = ($urandom_range(0, 3) != 0);
      a_select = ($urandom_range(0, 3) == 0);
      weights_flat          = NNZ*BW'($urandom);
      weight_mask           = TOT'($urandom);
      activation_flat       = 8'($urandom);
      activation_index_flat = 4'($urandom);
      for (int c = 0; c < COL; c++)
        psum_in_flat[c*PBW +: PBW] = ($urandom_range(0, 7) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                                                   : 20'($urandom);
      step();
    end

    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
